// File: rtl/prog_baud_gen_if.sv
// Control/status bundle between the config logic and the baud tick generator.
// The master drives the enable/clear/divisor-write side; the slave (the
// generator) returns the tick pulses, live counts and divisor status.
interface prog_baud_gen_if #(
  parameter int N     = 16,
  parameter int OVS_W = 4
);
  logic             i_en;
  logic             i_clr;
  logic             i_div_wr;
  logic [N-1:0]     i_div;
  logic             o_tick;
  logic             o_bit_tick;
  logic [N-1:0]     o_count;
  logic [OVS_W-1:0] o_ovs_count;
  logic             o_div_pend;
  logic             o_div_err;

  modport master (
    output i_en, i_clr, i_div_wr, i_div,
    input  o_tick, o_bit_tick, o_count, o_ovs_count, o_div_pend, o_div_err
  );

  modport slave (
    input  i_en, i_clr, i_div_wr, i_div,
    output o_tick, o_bit_tick, o_count, o_ovs_count, o_div_pend, o_div_err
  );
endinterface

// File: rtl/prog_baud_gen.sv
// Runtime-programmable mod-M baud tick generator.
// A sample counter wraps every div_act cycles and emits o_tick; every OVS
// wraps an oversample counter also emits o_bit_tick. A newly written divisor
// is parked in a pending register and only takes effect on a wrap or clear,
// so the active period is never cut short or stretched mid-count.
// DIV_RST and every accepted divisor must be >= 2.
module prog_baud_gen #(
  parameter int N       = 16,
  parameter int DIV_RST = 163,
  parameter int OVS     = 16,
  parameter int OVS_W   = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  prog_baud_gen_if.slave bus
);

  localparam logic [N-1:0]     CNT_ONE  = N'(1);
  localparam logic [N-1:0]     DIV_MIN  = N'(2);
  localparam logic [N-1:0]     DIV_INIT = N'(DIV_RST);
  localparam logic [OVS_W-1:0] OVS_ONE  = OVS_W'(1);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  logic [N-1:0]     cnt_reg, cnt_next;
  logic [OVS_W-1:0] ovs_reg, ovs_next;
  logic [N-1:0]     div_act_reg, div_act_next;
  logic [N-1:0]     div_pend_reg, div_pend_next;
  logic             pend_reg, pend_next;
  logic             tick_reg, tick_next;
  logic             bit_tick_reg, bit_tick_next;
  logic             err_reg, err_next;

  logic wrap;
  logic ovs_last;
  logic wr_ok;
  logic wr_bad;
  logic apply_div;

  // Wrap happens on the last count of the active period; a clear pre-empts it.
  assign wrap      = bus.i_en & ~bus.i_clr & (cnt_reg == (div_act_reg - CNT_ONE));
  assign ovs_last  = (ovs_reg == OVS_LAST);
  assign wr_ok     = bus.i_div_wr & (bus.i_div >= DIV_MIN);
  assign wr_bad    = bus.i_div_wr & ~wr_ok;
  // Only a divisor that was already pending before this edge is applied.
  assign apply_div = (wrap | bus.i_clr) & pend_reg;

  // Next-state for counters, tick pulses and the divisor registers.
  always_comb begin
    cnt_next      = cnt_reg;
    ovs_next      = ovs_reg;
    tick_next     = 1'b0;
    bit_tick_next = 1'b0;
    div_act_next  = div_act_reg;
    div_pend_next = div_pend_reg;
    pend_next     = pend_reg;
    err_next      = wr_bad;

    if (bus.i_clr) begin
      cnt_next = '0;
      ovs_next = '0;
    end else if (wrap) begin
      cnt_next      = '0;
      tick_next     = 1'b1;
      ovs_next      = ovs_last ? '0 : (ovs_reg + OVS_ONE);
      bit_tick_next = ovs_last;
    end else if (bus.i_en) begin
      cnt_next = cnt_reg + CNT_ONE;
    end

    if (apply_div) begin
      div_act_next = div_pend_reg;
      pend_next    = 1'b0;
    end

    // A fresh valid write always wins the pending slot, even on an apply cycle.
    if (wr_ok) begin
      div_pend_next = bus.i_div;
      pend_next     = 1'b1;
    end
  end

  // State registers; reset discards any pending divisor.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg      <= '0;
      ovs_reg      <= '0;
      div_act_reg  <= DIV_INIT;
      div_pend_reg <= '0;
      pend_reg     <= 1'b0;
      tick_reg     <= 1'b0;
      bit_tick_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      ovs_reg      <= ovs_next;
      div_act_reg  <= div_act_next;
      div_pend_reg <= div_pend_next;
      pend_reg     <= pend_next;
      tick_reg     <= tick_next;
      bit_tick_reg <= bit_tick_next;
      err_reg      <= err_next;
    end
  end

  assign bus.o_tick      = tick_reg;
  assign bus.o_bit_tick  = bit_tick_reg;
  assign bus.o_count     = cnt_reg;
  assign bus.o_ovs_count = ovs_reg;
  assign bus.o_div_pend  = pend_reg;
  assign bus.o_div_err   = err_reg;

endmodule

// File: tb/tb_prog_baud_gen.sv
// Directed bench for prog_baud_gen with DIV_RST=4, OVS=4.
module tb_prog_baud_gen;
  localparam int N       = 16;
  localparam int DIV_RST = 4;
  localparam int OVS     = 4;
  localparam int OVS_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prog_baud_gen_if #(.N(N), .OVS_W(OVS_W)) bus ();

  prog_baud_gen #(
    .N(N), .DIV_RST(DIV_RST), .OVS(OVS), .OVS_W(OVS_W)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_div(input logic [N-1:0] v);
    bus.i_div_wr = 1'b1;
    bus.i_div    = v;
    step();
    bus.i_div_wr = 1'b0;
  endtask

  // Advance from count 'start' through the wrap of a 'len'-cycle period.
  task automatic run_from(input string t, input int start, input int len,
                          input int exp_ovs, input logic exp_bit);
    for (int i = start + 1; i <= len; i++) begin
      step();
      chk({t, "/count"}, 32'(bus.o_count), (i == len) ? 32'd0 : 32'(i));
      chk({t, "/tick"}, 32'(bus.o_tick), (i == len) ? 32'd1 : 32'd0);
      chk({t, "/bit_tick"}, 32'(bus.o_bit_tick), (i == len) ? 32'(exp_bit) : 32'd0);
    end
    chk({t, "/ovs"}, 32'(bus.o_ovs_count), 32'(exp_ovs));
  endtask

  initial begin
    bus.i_en     = 1'b0;
    bus.i_clr    = 1'b0;
    bus.i_div_wr = 1'b0;
    bus.i_div    = '0;

    // Reset state
    step();
    step();
    chk("rst/count", 32'(bus.o_count), 0);
    chk("rst/ovs", 32'(bus.o_ovs_count), 0);
    chk("rst/tick", 32'(bus.o_tick), 0);
    chk("rst/bit_tick", 32'(bus.o_bit_tick), 0);
    chk("rst/pend", 32'(bus.o_div_pend), 0);
    chk("rst/err", 32'(bus.o_div_err), 0);

    // T1: enable from reset release, ticks at 4,8,12,16; bit tick at 16
    bus.i_en = 1'b1;
    rst_n    = 1'b1;
    run_from("t1a", 0, 4, 1, 1'b0);
    run_from("t1b", 0, 4, 2, 1'b0);
    run_from("t1c", 0, 4, 3, 1'b0);
    run_from("t1d", 0, 4, 0, 1'b1);

    // T2: pause 3 cycles at count 2
    step();
    step();
    chk("t2/count_pre", 32'(bus.o_count), 2);
    bus.i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2/hold_count", 32'(bus.o_count), 2);
      chk("t2/hold_tick", 32'(bus.o_tick), 0);
    end
    bus.i_en = 1'b1;
    run_from("t2", 2, 4, 1, 1'b0);

    // T3: write 6 at count 1; current period stays 4, then 6
    step();
    write_div(16'd6);
    chk("t3/count", 32'(bus.o_count), 2);
    chk("t3/pend", 32'(bus.o_div_pend), 1);
    run_from("t3a", 2, 4, 2, 1'b0);
    chk("t3/pend_cleared", 32'(bus.o_div_pend), 0);
    run_from("t3b", 0, 6, 3, 1'b0);

    // T4a: rejected write of 1
    write_div(16'd1);
    chk("t4a/err", 32'(bus.o_div_err), 1);
    chk("t4a/pend", 32'(bus.o_div_pend), 0);
    chk("t4a/count", 32'(bus.o_count), 1);
    step();
    chk("t4a/err_pulse", 32'(bus.o_div_err), 0);
    chk("t4a/count2", 32'(bus.o_count), 2);
    run_from("t4a", 2, 6, 0, 1'b1);

    // T4b: pending 6, then write 5 on the wrap cycle
    write_div(16'd6);
    chk("t4b/pend", 32'(bus.o_div_pend), 1);
    chk("t4b/count", 32'(bus.o_count), 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("t4b/count_run", 32'(bus.o_count), 32'(k));
    end
    write_div(16'd5);
    chk("t4b/wrap_tick", 32'(bus.o_tick), 1);
    chk("t4b/wrap_count", 32'(bus.o_count), 0);
    chk("t4b/pend_kept", 32'(bus.o_div_pend), 1);
    chk("t4b/ovs", 32'(bus.o_ovs_count), 1);
    run_from("t4b6", 0, 6, 2, 1'b0);
    chk("t4b/pend_cleared", 32'(bus.o_div_pend), 0);
    run_from("t4b5", 0, 5, 3, 1'b0);

    // T5: clear at count 3, ovs 2, with 8 pending
    run_from("t5a", 0, 5, 0, 1'b1);
    run_from("t5b", 0, 5, 1, 1'b0);
    run_from("t5c", 0, 5, 2, 1'b0);
    write_div(16'd8);
    chk("t5/pend", 32'(bus.o_div_pend), 1);
    step();
    step();
    chk("t5/count_pre", 32'(bus.o_count), 3);
    chk("t5/ovs_pre", 32'(bus.o_ovs_count), 2);
    bus.i_clr = 1'b1;
    step();
    bus.i_clr = 1'b0;
    chk("t5/clr_count", 32'(bus.o_count), 0);
    chk("t5/clr_ovs", 32'(bus.o_ovs_count), 0);
    chk("t5/clr_tick", 32'(bus.o_tick), 0);
    chk("t5/clr_bit", 32'(bus.o_bit_tick), 0);
    chk("t5/clr_pend", 32'(bus.o_div_pend), 0);
    run_from("t5d", 0, 8, 1, 1'b0);

    // T6: async reset mid-count with a pending divisor
    write_div(16'd10);
    chk("t6/pend", 32'(bus.o_div_pend), 1);
    step();
    step();
    chk("t6/count_pre", 32'(bus.o_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6/count", 32'(bus.o_count), 0);
    chk("t6/ovs", 32'(bus.o_ovs_count), 0);
    chk("t6/tick", 32'(bus.o_tick), 0);
    chk("t6/bit_tick", 32'(bus.o_bit_tick), 0);
    chk("t6/pend_rst", 32'(bus.o_div_pend), 0);
    chk("t6/err", 32'(bus.o_div_err), 0);
    step();
    rst_n = 1'b1;
    run_from("t6a", 0, 4, 1, 1'b0);
    chk("t6/pend_after", 32'(bus.o_div_pend), 0);
    run_from("t6b", 0, 4, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
